// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg: shared definitions for the scan/direct one-hot decoder.
//   mode_e      : Mode input encoding (direct decode vs auto-scan)
//   dwell_width : width of the dwell counter for a given DWELL
package scan_decoder_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // A dwell of 1 still needs a 1-bit counter so the port/reg widths stay legal.
    function automatic int dwell_width(input int dwell);
        return (dwell > 1) ? $clog2(dwell) : 1;
    endfunction

endpackage

// File: rtl/scan_decoder_dec_core.sv
// dec_core: purely combinational N-to-2^N one-hot decoder with enable.
//   w  : select
//   En : enable; 0 forces all outputs low
//   y  : one-hot result, y[k] = 1 selects position k
module dec_core #(
    parameter int N = 4
) (
    input  logic [N-1:0]    w,
    input  logic            En,
    output logic [0:2**N-1] y
);

    always_comb begin
        y = '0;
        if (En) begin
            y[w] = 1'b1;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered N-to-2^N one-hot strobe generator.
// In direct mode it decodes w; in scan mode an internal index walks every
// position, holding each for DWELL cycles.
//   Clock : rising-edge clock
//   Reset : synchronous, active-high reset
//   En    : enable; 0 forces y low and freezes the scan
//   Mode  : 0 = direct decode, 1 = auto-scan
//   Load  : scan mode only, loads the index from w
//   w     : select (direct) / load value (scan)
//   y     : registered one-hot strobe, y[k] = 1 selects position k
//   Idx   : index currently decoded
//   Wrap  : one-cycle pulse when the scan index wraps to 0
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int N     = 4,
    parameter int DWELL = 4
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            En,
    input  logic            Mode,
    input  logic            Load,
    input  logic [N-1:0]    w,
    output logic [0:2**N-1] y,
    output logic [N-1:0]    Idx,
    output logic            Wrap
);

    localparam int            DW         = dwell_width(DWELL);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    logic [DW-1:0]    dwell;
    logic [DW-1:0]    next_dwell;
    logic [N-1:0]     next_idx;
    logic             next_wrap;
    logic [0:2**N-1]  y_next;

    // Next index/dwell; with En low everything holds, so y re-appears as
    // one-hot(Idx) on the first enabled edge and the remaining dwell resumes.
    always_comb begin
        next_idx   = Idx;
        next_dwell = dwell;
        next_wrap  = 1'b0;
        if (En) begin
            if (mode_e'(Mode) == MODE_DIRECT || Load) begin
                next_idx   = w;
                next_dwell = '0;
            end else if (dwell == DWELL_LAST) begin
                next_dwell = '0;
                next_idx   = Idx + 1'b1;
                next_wrap  = (Idx == '1);
            end else begin
                next_dwell = dwell + 1'b1;
            end
        end
    end

    // Decoding the next index (not the current one) keeps y aligned with Idx.
    dec_core #(.N(N)) u_dec (
        .w  (next_idx),
        .En (En),
        .y  (y_next)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            y     <= '0;
            Idx   <= '0;
            dwell <= '0;
            Wrap  <= 1'b0;
        end else begin
            y     <= y_next;
            Idx   <= next_idx;
            dwell <= next_dwell;
            Wrap  <= next_wrap;
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: self-checking bench for scan_decoder.
// Two instances: N=4/DWELL=2 (main) and N=4/DWELL=1. Both are compared every
// cycle against a behavioural model; directed steps add explicit expectations.
module tb_scan_decoder;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int D0 = 2;
    localparam int D1 = 1;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic           rst_i  [2];
    logic           en_i   [2];
    logic           mode_i [2];
    logic           load_i [2];
    logic [N-1:0]   w_i    [2];
    logic [0:W-1]   y_o    [2];
    logic [N-1:0]   idx_o  [2];
    logic           wrap_o [2];

    scan_decoder #(.N(N), .DWELL(D0)) dut0 (
        .Clock (Clock),
        .Reset (rst_i[0]),
        .En    (en_i[0]),
        .Mode  (mode_i[0]),
        .Load  (load_i[0]),
        .w     (w_i[0]),
        .y     (y_o[0]),
        .Idx   (idx_o[0]),
        .Wrap  (wrap_o[0])
    );

    scan_decoder #(.N(N), .DWELL(D1)) dut1 (
        .Clock (Clock),
        .Reset (rst_i[1]),
        .En    (en_i[1]),
        .Mode  (mode_i[1]),
        .Load  (load_i[1]),
        .w     (w_i[1]),
        .y     (y_o[1]),
        .Idx   (idx_o[1]),
        .Wrap  (wrap_o[1])
    );

    int total  = 0;
    int passed = 0;

    // Model state: current position, cycles spent at it, strobe on, wrap pulse.
    int m_idx  [2];
    int m_cnt  [2];
    bit m_on   [2];
    bit m_wrap [2];

    function automatic logic [0:W-1] onehot(input int k);
        logic [0:W-1] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic [0:W-1] model_y(input int i);
        return m_on[i] ? onehot(m_idx[i]) : '0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic model_step(input int i, input int dwell);
        if (rst_i[i]) begin
            m_idx[i] = 0; m_cnt[i] = 0; m_on[i] = 0; m_wrap[i] = 0;
        end else if (!en_i[i]) begin
            m_on[i] = 0; m_wrap[i] = 0;
        end else if (!mode_i[i] || load_i[i]) begin
            m_idx[i] = int'(w_i[i]); m_cnt[i] = 0; m_on[i] = 1; m_wrap[i] = 0;
        end else begin
            m_on[i]   = 1;
            m_wrap[i] = 0;
            m_cnt[i]  = m_cnt[i] + 1;
            if (m_cnt[i] == dwell) begin
                m_cnt[i]  = 0;
                m_idx[i]  = (m_idx[i] + 1) % W;
                m_wrap[i] = (m_idx[i] == 0);
            end
        end
    endtask

    // One clock edge: advance the model, then compare both DUTs 1 ns later.
    task automatic cycle();
        @(posedge Clock);
        model_step(0, D0);
        model_step(1, D1);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d_y", i),    32'(y_o[i]),    32'(model_y(i)));
            chk($sformatf("u%0d_idx", i),  32'(idx_o[i]),  32'(m_idx[i]));
            chk($sformatf("u%0d_wrap", i), 32'(wrap_o[i]), 32'(m_wrap[i]));
        end
    endtask

    task automatic drive(input int i, input logic r, input logic e, input logic m,
                         input logic l, input int wv);
        rst_i[i]  = r;
        en_i[i]   = e;
        mode_i[i] = m;
        load_i[i] = l;
        w_i[i]    = N'(wv);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            drive(i, 1'b1, 1'b1, 1'b1, 1'b0, 0);
            m_idx[i] = 0; m_cnt[i] = 0; m_on[i] = 0; m_wrap[i] = 0;
        end

        // Reset held two cycles while enabled in scan mode.
        cycle();
        cycle();
        chk("rst_y",    32'(y_o[0]),   32'h0);
        chk("rst_idx",  32'(idx_o[0]), 32'h0);
        chk("rst_wrap", 32'(wrap_o[0]), 32'h0);
        drive(0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        cycle();
        chk("post_rst_y", 32'(y_o[0]), 32'(onehot(0)));

        // Direct decode of every select value.
        for (int k = 0; k < W; k++) begin
            drive(0, 1'b0, 1'b1, 1'b0, 1'b0, k);
            cycle();
            chk($sformatf("direct_y_%0d", k),   32'(y_o[0]),   32'(onehot(k)));
            chk($sformatf("direct_idx_%0d", k), 32'(idx_o[0]), k);
        end
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        cycle();
        chk("dis_y",   32'(y_o[0]),   32'h0);
        chk("dis_idx", 32'(idx_o[0]), 15);

        // Full scan from 0: each position held 2 cycles, wrap once.
        drive(0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        cycle();
        drive(0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        for (int c = 1; c <= 34; c++) begin
            cycle();
            chk($sformatf("scan_idx_%0d", c),  32'(idx_o[0]),  (c / 2) % W);
            chk($sformatf("scan_wrap_%0d", c), 32'(wrap_o[0]), (c == 32) ? 1 : 0);
        end

        // Load coinciding with a dwell advance: Load wins and dwell restarts.
        cycle();
        chk("pre_load_idx", 32'(idx_o[0]), 1);
        drive(0, 1'b0, 1'b1, 1'b1, 1'b1, 9);
        cycle();
        chk("load_idx", 32'(idx_o[0]), 9);
        drive(0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        cycle();
        chk("load_hold_idx", 32'(idx_o[0]), 9);
        cycle();
        chk("load_adv_idx", 32'(idx_o[0]), 10);

        // Disable in the middle of position 6, then resume the remaining dwell.
        drive(0, 1'b0, 1'b1, 1'b1, 1'b1, 6);
        cycle();
        drive(0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("frz_y",   32'(y_o[0]),   32'h0);
            chk("frz_idx", 32'(idx_o[0]), 6);
        end
        drive(0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        cycle();
        chk("resume_y",   32'(y_o[0]),   32'(onehot(6)));
        chk("resume_idx", 32'(idx_o[0]), 6);
        cycle();
        chk("resume_adv_idx", 32'(idx_o[0]), 7);

        // DWELL=1: natural wrap, then reset on the wrap edge.
        drive(1, 1'b0, 1'b1, 1'b1, 1'b1, 15);
        cycle();
        chk("d1_load_idx", 32'(idx_o[1]), 15);
        drive(1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        cycle();
        chk("d1_wrap_idx", 32'(idx_o[1]),  0);
        chk("d1_wrap",     32'(wrap_o[1]), 1);
        drive(1, 1'b0, 1'b1, 1'b1, 1'b1, 15);
        cycle();
        drive(1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        cycle();
        chk("d1_rst_idx",  32'(idx_o[1]),  0);
        chk("d1_rst_y",    32'(y_o[1]),    32'h0);
        chk("d1_rst_wrap", 32'(wrap_o[1]), 0);

        // Randomised traffic on both instances against the model.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                drive(i,
                      ($urandom_range(0, 31) == 0),
                      ($urandom_range(0, 7) != 0),
                      ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 7) == 0),
                      int'($urandom_range(0, W - 1)));
            end
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
